// File: rtl/seg7_scan_if.sv
// seg7_scan_if: write port of the two-digit 7-segment scanner.
// The bus side drives a digit pair plus decimal points and receives an ack.
interface seg7_scan_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [1:0] wr_dp;
    logic       wr_ack;

    modport master (
        output wr_en,
        output wr_data,
        output wr_dp,
        input  wr_ack
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  wr_dp,
        output wr_ack
    );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: two-digit multiplexed 7-segment driver with frame-atomic updates.
// Optional macro SEG7_BLINK_EN adds a 64-frame blink counter gated by 'blink'.
module seg7_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEAD           = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    seg7_scan_if.slave  bus,
    input  logic        blank,
    input  logic        blink,
    output logic [7:0]  SEG_o,
    output logic [1:0]  COM_o
);

    localparam logic [15:0] LAST    = 16'(SCAN_DIV - 1);
    localparam logic [15:0] DEAD_C  = 16'(DEAD);
    localparam logic [7:0]  SEG_INV = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [1:0]  COM_INV = COM_ACTIVE_LOW ? 2'b11 : 2'b00;

    logic [15:0] cnt_q, cnt_d;
    logic        sel_q, sel_d;
    logic [9:0]  shadow_q, shadow_d;
    logic [9:0]  active_q, active_d;
    logic        ack_q, ack_d;
    logic [7:0]  seg_q, seg_d;
    logic [1:0]  com_q, com_d;

    logic        wrap;
    logic        frame_end;
    logic        blink_off;
    logic [3:0]  nib;
    logic        dp_bit;
    logic [6:0]  glyph;
    logic [1:0]  com_raw;

`ifdef SEG7_BLINK_EN
    logic [5:0]  blink_cnt_q, blink_cnt_d;
`else
    logic        unused_blink;
    assign unused_blink = blink;
`endif

    // Hex nibble to active-high gfedcba pattern.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Next-state: prescaler, digit select, shadow/active data and pin drive.
    always_comb begin
        wrap      = (cnt_q == LAST);
        frame_end = wrap & sel_q;

        cnt_d    = wrap ? 16'd0 : cnt_q + 16'd1;
        sel_d    = sel_q ^ wrap;
        ack_d    = bus.wr_en;
        shadow_d = bus.wr_en ? {bus.wr_dp, bus.wr_data} : shadow_q;
        // Copy the pre-write shadow so a frame never mixes old and new data.
        active_d = frame_end ? shadow_q : active_q;

`ifdef SEG7_BLINK_EN
        blink_cnt_d = frame_end ? blink_cnt_q + 6'd1 : blink_cnt_q;
        blink_off   = blink & blink_cnt_q[5];
`else
        blink_off   = 1'b0;
`endif

        nib    = sel_q ? active_q[7:4] : active_q[3:0];
        dp_bit = sel_q ? active_q[9] : active_q[8];
        glyph  = decode(nib);

        com_raw = 2'b00;
        if (cnt_q >= DEAD_C) begin
            com_raw = sel_q ? 2'b10 : 2'b01;
        end

        seg_d = (blank | blink_off) ? 8'h00 : {dp_bit, glyph};
        seg_d = seg_d ^ SEG_INV;
        com_d = com_raw ^ COM_INV;
    end

    // State and registered pins, cleared to idle/off by synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q    <= 16'd0;
            sel_q    <= 1'b0;
            shadow_q <= 10'd0;
            active_q <= 10'd0;
            ack_q    <= 1'b0;
            seg_q    <= SEG_INV;
            com_q    <= COM_INV;
`ifdef SEG7_BLINK_EN
            blink_cnt_q <= 6'd0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            ack_q    <= ack_d;
            seg_q    <= seg_d;
            com_q    <= com_d;
`ifdef SEG7_BLINK_EN
            blink_cnt_q <= blink_cnt_d;
`endif
        end
    end

    assign bus.wr_ack = ack_q;
    assign SEG_o      = seg_q;
    assign COM_o      = com_q;

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit period, legal range 4..65535.
REQ-002 The block SHALL have parameter DEAD, default 16: cycles at the start of each digit period with both commons off; legal range 0..SCAN_DIV-2.
REQ-003 The block SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 means a lit segment drives 0.
REQ-004 The block SHALL have parameter COM_ACTIVE_LOW, default 1: 1 means an enabled digit common drives 0.
REQ-005 Port clk, input, 1 bit: the single clock.
REQ-006 Port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port wr_en, input, 1 bit: write strobe from the bus side.
REQ-008 Port wr_data, input, 8 bits: [3:0] is the digit 0 hex value, [7:4] is the digit 1 hex value.
REQ-009 Port wr_dp, input, 2 bits: decimal point per digit, written with wr_data.
REQ-010 Port blank, input, 1 bit: level; forces all segments off while high.
REQ-011 Port blink, input, 1 bit: level; blink request, used only per REQ-030.
REQ-012 Port wr_ack, output, 1 bit: one-cycle pulse acknowledging a write.
REQ-013 Port SEG_o, output, 8 bits: segment drive, {dp,g,f,e,d,c,b,a}.
REQ-014 Port COM_o, output, 2 bits: digit commons; bit 0 selects digit 0.

Function
REQ-015 The prescaler SHALL count 0..SCAN_DIV-1, incrementing every cycle and wrapping to 0 after SCAN_DIV-1.
REQ-016 The digit select SHALL toggle on the cycle the prescaler wraps; a frame is digit 0 followed by digit 1.
REQ-017 A cycle with wr_en=1 at a clk edge SHALL load {wr_dp, wr_data} into the shadow register, and wr_ack SHALL be 1 in the following cycle only.
REQ-018 The active register SHALL copy the shadow register only on the wrap in which the digit select goes 1->0 (frame boundary), so a frame never mixes old and new data.
REQ-019 When wr_en is asserted on the same cycle as a frame-boundary copy, the copy SHALL take the old shadow value, and the new value SHALL appear in the next frame.
REQ-020 Back-to-back writes SHALL each be acknowledged; the last write before a frame boundary SHALL win.
REQ-021 The nibble decode SHALL use the active-high gfedcba values 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-022 SEG_o[7] SHALL be the dp bit of the selected digit.
REQ-023 SEG_o and COM_o SHALL be registered outputs, with one cycle of latency from prescaler/select state to pins.
REQ-024 COM_o SHALL enable only the selected digit while the prescaler value is at least DEAD, and SHALL have both digits disabled while it is below DEAD.
REQ-025 While blank=1, SEG_o SHALL be all segments off; COM_o scanning SHALL continue unchanged.
REQ-026 Output polarity SHALL be applied last, by inversion per SEG_ACTIVE_LOW and COM_ACTIVE_LOW.

Reset
REQ-027 While resetn=0 at a clk edge, the prescaler, digit select, shadow register, active register and blink counter SHALL clear to 0.
REQ-028 While resetn=0 at a clk edge, wr_ack SHALL be 0, SEG_o SHALL be all segments off, and COM_o SHALL have both digits off (both polarity-adjusted).
REQ-029 Reset asserted mid-frame or mid-write SHALL discard any pending shadow data, and scanning SHALL restart at digit 0, count 0, on the first cycle after release.

Configuration
REQ-030 With macro SEG7_BLINK_EN defined, a 6-bit blink counter SHALL increment at each frame boundary, and while blink=1 and counter[5]=1 the segments SHALL be off (32 frames on, 32 off).
REQ-031 Without SEG7_BLINK_EN, the blink counter SHALL be absent, the blink input SHALL be ignored, and the port SHALL remain for a pin-compatible instantiation.

Verification (SCAN_DIV=4, DEAD=1, both polarities active-low unless stated)
REQ-032 Reset: hold resetn=0 for 3 cycles -> SEG_o=FF, COM_o=11, wr_ack=0; after release, COM_o=10 (digit 0 on) starting at the cycle after prescaler=1.
REQ-033 Write: wr_en=1, wr_data=0x3A, wr_dp=01 mid-frame -> wr_ack pulses once; old data remains until the frame boundary; then digit 0 shows SEG_o=~{1,77}=0x08 and digit 1 shows ~{0,4F}=0xB0.
REQ-034 Boundary race: wr_en on the exact frame-boundary cycle with 0x55 over 0x00 -> the next frame shows 00 and the frame after shows 55.
REQ-035 Blank and dead time: blank=1 -> SEG_o=FF while COM_o keeps toggling; COM_o=11 for exactly 1 cycle at the start of each digit period.
REQ-036 Blink: with SEG7_BLINK_EN and blink=1 -> segments off for frames 32..63, lit for frames 0..31; without the macro -> always lit.
REQ-037 Polarity: SEG_ACTIVE_LOW=0, COM_ACTIVE_LOW=0, data 0x88 -> SEG_o=7F, COM_o one-hot active-high.
